// File: rtl/and_tree_sequencer_pkg.sv
// Shared types and constants for the AND-tree test sequencer.
package and_tree_pkg;

  localparam int unsigned VEC_W    = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned FAIL_MAX = 255;
  localparam int unsigned STB_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic             pass;
    logic [CNT_W-1:0] latency;
  } rsp_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/and_tree_sequencer_if.sv
// Vector request, leaf drive, tree feedback and result signals.
interface and_tree_sequencer_if;
  import and_tree_pkg::*;

  logic             vec_valid;
  logic [VEC_W-1:0] vec_data;
  logic             vec_ready;
  logic             a, b, c, d;
  logic             z;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_pass;
  logic [CNT_W-1:0] rsp_latency;
  logic [CNT_W-1:0] fail_count;

  // Stimulus / consumer side
  modport master (
    output vec_valid, vec_data, z, rsp_ready,
    input  vec_ready, a, b, c, d, rsp_valid, rsp_pass, rsp_latency, fail_count
  );

  // Sequencer side
  modport slave (
    input  vec_valid, vec_data, z, rsp_ready,
    output vec_ready, a, b, c, d, rsp_valid, rsp_pass, rsp_latency, fail_count
  );
endinterface

// File: rtl/and_tree_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous tree output.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  // Both stages clear on reset so z reads as 0 until real samples arrive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/and_tree_sequencer.sv
// Applies a 4-bit vector to an AND tree, waits for the synchronized output
// to settle at the expected value for STABLE cycles, and reports pass/latency.
module and_tree_sequencer
  import and_tree_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int STABLE  = 2
) (
  input logic            clk,
  input logic            reset,
  and_tree_sequencer_if.slave bus
);

  state_t           state;
  logic [VEC_W-1:0] vec_q;
  logic             expected;
  logic [CNT_W-1:0] lat_cnt;
  logic [STB_W-1:0] stb_cnt;
  logic [CNT_W-1:0] run_start;
  rsp_t             rsp_q;
  logic             rsp_valid_q;
  logic             vec_ready_q;
  logic [CNT_W-1:0] fail_cnt;
  logic             z_sync;

  logic [CNT_W-1:0] lat_n;
  logic [STB_W-1:0] stb_n;
  logic             hit;
  logic             pass_n;
  logic             tmo_n;
  logic [CNT_W-1:0] run_n;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.z),
    .q     (z_sync)
  );

  // WAIT-state bookkeeping: latency of this sample, stable-run length,
  // where the current run began, and the pass/timeout decisions.
  always_comb begin
    lat_n  = sat_inc(lat_cnt);
    hit    = (z_sync == expected);
    stb_n  = '0;
    run_n  = run_start;
    if (hit) begin
      stb_n = (stb_cnt == {STB_W{1'b1}}) ? stb_cnt : stb_cnt + 1'b1;
      if (stb_cnt == '0) run_n = lat_n;
    end
    pass_n = (stb_n >= STB_W'(STABLE));
    tmo_n  = (lat_n >= CNT_W'(TIMEOUT));
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vec_q       <= '0;
      expected    <= 1'b0;
      lat_cnt     <= '0;
      stb_cnt     <= '0;
      run_start   <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      vec_ready_q <= 1'b1;
      fail_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.vec_valid && vec_ready_q) begin
            vec_q       <= bus.vec_data;
            expected    <= &bus.vec_data;
            vec_ready_q <= 1'b0;
            state       <= DRIVE;
          end
        end
        DRIVE: begin
          lat_cnt   <= '0;
          stb_cnt   <= '0;
          run_start <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          lat_cnt   <= lat_n;
          stb_cnt   <= stb_n;
          run_start <= run_n;
          // A pass on the same cycle as the timeout takes priority.
          if (pass_n) begin
            rsp_q.pass    <= 1'b1;
            rsp_q.latency <= run_n;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end else if (tmo_n) begin
            rsp_q.pass    <= 1'b0;
            rsp_q.latency <= CNT_W'(TIMEOUT);
            rsp_valid_q   <= 1'b1;
            if (fail_cnt != CNT_W'(FAIL_MAX)) fail_cnt <= fail_cnt + 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            vec_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a           = vec_q[3];
  assign bus.b           = vec_q[2];
  assign bus.c           = vec_q[1];
  assign bus.d           = vec_q[0];
  assign bus.vec_ready   = vec_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_pass    = rsp_q.pass;
  assign bus.rsp_latency = rsp_q.latency;
  assign bus.fail_count  = fail_cnt;

endmodule

// File: tb/tb_and_tree_sequencer.sv
// Directed scoreboard bench for the AND-tree sequencer.
module tb_and_tree_sequencer;
  import and_tree_pkg::*;

  typedef struct {
    logic       pass;
    logic [7:0] lat;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  and_tree_sequencer_if bus();

  and_tree_sequencer #(.TIMEOUT(64), .STABLE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Tree model: AND of the leaves, three clocks of propagation delay.
  logic [2:0] pipe;
  int         zmode;   // 0 = delayed tree, 1 = stuck 0, 2 = manual
  logic       zman;
  always @(posedge clk or posedge reset) begin
    if (reset) pipe <= '0;
    else       pipe <= {pipe[1:0], bus.a & bus.b & bus.c & bus.d};
  end
  assign bus.z = (zmode == 0) ? pipe[2] : (zmode == 1) ? 1'b0 : zman;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] v);
    check("vec_ready_before_send", bus.vec_ready, 1);
    bus.vec_valid = 1'b1;
    bus.vec_data  = v;
    tick();
    bus.vec_valid = 1'b0;
    check("leaves_driven", {bus.a, bus.b, bus.c, bus.d}, v);
    check("vec_ready_busy", bus.vec_ready, 0);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    exp_t e;
    while (!bus.rsp_valid && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_rsp_seen"}, bus.rsp_valid, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pass"}, bus.rsp_pass, e.pass);
      check({tag, "_latency"}, bus.rsp_latency, e.lat);
      check({tag, "_fail_count"}, bus.fail_count, e.fc);
    end
  endtask

  task automatic ack(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_cleared"}, bus.rsp_valid, 0);
    check({tag, "_vec_ready_back"}, bus.vec_ready, 1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.vec_valid = 1'b0;
    bus.vec_data  = '0;
    bus.rsp_ready = 1'b0;
    zmode         = 0;
    zman          = 1'b0;
    #2;
    // Reset state
    check("rst_leaves", {bus.a, bus.b, bus.c, bus.d}, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_pass", bus.rsp_pass, 0);
    check("rst_rsp_latency", bus.rsp_latency, 0);
    check("rst_fail_count", bus.fail_count, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_vec_ready", bus.vec_ready, 1);

    // 0111, z already synced 0: passes on the first sample
    exp_q.push_back('{1'b1, 8'd1, 8'd0});
    send(4'b0111);
    wait_rsp("v0111");
    ack("v0111");

    // 1111 through the delayed tree: 2 sync + 3 propagation
    exp_q.push_back('{1'b1, 8'd5, 8'd0});
    send(4'b1111);
    wait_rsp("v1111");
    ack("v1111");

    // Stuck-0 output: timeout, fail_count bumps
    zmode = 1;
    repeat (4) tick();
    exp_q.push_back('{1'b0, 8'd64, 8'd1});
    send(4'b1111);
    wait_rsp("stuck0");
    ack("stuck0");

    // Glitch 1-0-1: only the second run of ones counts
    zmode = 2;
    zman  = 1'b0;
    exp_q.push_back('{1'b1, 8'd7, 8'd1});
    send(4'b1111);
    tick(); tick(); tick();
    zman = 1'b1;
    tick();
    zman = 1'b0;
    tick();
    zman = 1'b1;
    wait_rsp("glitch");

    // Consumer stalls for 10 cycles; offered vector must be ignored
    bus.vec_valid = 1'b1;
    bus.vec_data  = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 9) begin
        check("hold_rsp_valid", bus.rsp_valid, 1);
        check("hold_rsp_pass", bus.rsp_pass, 1);
        check("hold_rsp_latency", bus.rsp_latency, 7);
        check("hold_vec_ready", bus.vec_ready, 0);
        check("hold_leaves", {bus.a, bus.b, bus.c, bus.d}, 4'b1111);
      end
    end
    bus.vec_valid = 1'b0;
    ack("hold");

    // Reset mid-WAIT aborts without a response
    zmode = 1;
    repeat (4) tick();
    send(4'b1111);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("abort_leaves", {bus.a, bus.b, bus.c, bus.d}, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_fail_count", bus.fail_count, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("abort_vec_ready", bus.vec_ready, 1);
    check("abort_no_rsp", bus.rsp_valid, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
